// File: rtl/rf_wb_ctrl_pkg.sv
// rtl/rf_wb_ctrl_pkg.sv - shared write-back select encodings and controller state encoding
package rf_wb_ctrl_pkg;

  localparam logic [1:0] WB_SEL_MEM  = 2'b00;
  localparam logic [1:0] WB_SEL_ALU  = 2'b01;
  localparam logic [1:0] WB_SEL_OFF  = 2'b10;
  localparam logic [1:0] WB_SEL_HOST = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

endpackage

// File: rtl/rf_wb_src_decode.sv
// rtl/rf_wb_src_decode.sv - WB-stage opcode class flags to RF write-data source select
module rf_wb_src_decode
  import rf_wb_ctrl_pkg::*;
(
  input  logic       lw_wb,
  input  logic       addi_wb,
  input  logic       subi_wb,
  input  logic       movi_wb,
  output logic [1:0] wb_sel
);

  // Loads win over everything; MOVI yields to ADDI when both are flagged.
  always_comb begin
    wb_sel = WB_SEL_MEM;
    if (movi_wb && !lw_wb && !addi_wb)
      wb_sel = WB_SEL_OFF;
    else if (!lw_wb && (addi_wb || subi_wb))
      wb_sel = WB_SEL_ALU;
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - RF write-back mux control with host register access via pipeline drain
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int AW           = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic          LW_WB,
  input  logic          ADDI_WB,
  input  logic          SUBI_WB,
  input  logic          MOVI_WB,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [63:0]   rf_rdata,
  output logic [1:0]    wb_sel,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [AW-1:0] rf_raddr,
  output logic          pipe_stall,
  output logic          host_ack,
  output logic [63:0]   host_rdata
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     lat_addr;
  logic              lat_we;
  logic [1:0]        dec_sel;

  rf_wb_src_decode u_dec (
    .lw_wb   (LW_WB),
    .addi_wb (ADDI_WB),
    .subi_wb (SUBI_WB),
    .movi_wb (MOVI_WB),
    .wb_sel  (dec_sel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pipe_stall <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_req) begin
            lat_we     <= host_we;
            lat_addr   <= host_addr;
            cnt        <= DRAIN_LOAD;
            pipe_stall <= 1'b1;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (lat_we) begin
            host_ack   <= 1'b1;
            pipe_stall <= 1'b0;
            state      <= ST_ACK;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          host_rdata <= rf_rdata;
          host_ack   <= 1'b1;
          pipe_stall <= 1'b0;
          state      <= ST_ACK;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pipeline writeback keeps flowing while draining; host owns the port only in ACCESS.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_waddr;
    wb_sel   = dec_sel;
    case (state)
      ST_IDLE, ST_DRAIN: rf_we = wb_we & reset_n;
      ST_ACCESS: begin
        if (lat_we) begin
          rf_we    = 1'b1;
          rf_waddr = lat_addr;
          wb_sel   = WB_SEL_HOST;
        end
      end
      default: rf_we = 1'b0;
    endcase
  end

  assign rf_raddr = lat_addr;

endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 4, cycles of pipeline drain after stall before host owns the RF port (legal 1..15).
REQ-002 Parameter: AW, default 5, register-file address width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 wb_we  in  1  pipeline WB-stage register write enable.
REQ-006 wb_waddr  in  AW  pipeline WB-stage destination register.
REQ-007 LW_WB, ADDI_WB, SUBI_WB, MOVI_WB  in  1 each  WB-stage opcode class flags.
REQ-008 host_req  in  1  host RF access request, held until host_ack.
REQ-009 host_we  in  1  host access type: 1 = write, 0 = read; sampled with host_req.
REQ-010 host_addr  in  AW  host register address; sampled with host_req.
REQ-011 rf_rdata  in  64  RF read-port data, valid the cycle after rf_raddr is driven.
REQ-012 wb_sel  out  2  RF write-data source: 00 D_out, 01 ALU_out, 10 Offset, 11 host_wdata.
REQ-013 rf_we  out  1  RF write enable.
REQ-014 rf_waddr  out  AW  RF write address.
REQ-015 rf_raddr  out  AW  host read address to RF read port.
REQ-016 pipe_stall  out  1  freeze fetch/issue; in-flight instructions continue.
REQ-017 host_ack  out  1  one-cycle completion pulse.
REQ-018 host_rdata  out  64  captured read data, valid with host_ack, held until next read completes.

Function
REQ-019 FSM states: IDLE, DRAIN, ACCESS, CAPTURE, ACK.
REQ-020 IDLE: rf_we = wb_we, rf_waddr = wb_waddr, wb_sel decoded combinationally per REQ-021, pipe_stall = 0.
REQ-021 Decode priority: MOVI_WB & ~LW_WB & ~ADDI_WB -> 10; else ~LW_WB & (ADDI_WB | SUBI_WB) -> 01; else 00 (LW dominates everything).
REQ-022 IDLE & host_req: latch host_we/host_addr, load drain counter with DRAIN_CYCLES, assert pipe_stall, go DRAIN next cycle.
REQ-023 DRAIN: pipe_stall = 1, pipeline writeback still passes per REQ-020/021; counter decrements each cycle; at count 1 go ACCESS.
REQ-024 ACCESS, write: rf_we = 1, rf_waddr = latched addr, wb_sel = 11, one cycle, then ACK.
REQ-025 ACCESS, read: rf_raddr = latched addr, rf_we = 0, then CAPTURE.
REQ-026 CAPTURE: host_rdata <= rf_rdata, then ACK.
REQ-027 ACK: host_ack = 1 for exactly one cycle, pipe_stall released in the same cycle, return to IDLE.
REQ-028 In ACCESS/CAPTURE/ACK, wb_we is ignored (pipeline empty by construction); rf_we = 0 except for host write.
REQ-029 host_req still high in IDLE the cycle after ACK is a new request (host drops req on ack).
REQ-030 host_req dropped during DRAIN: request completes anyway; ack is still issued.
REQ-031 Total host write latency req->ack = DRAIN_CYCLES + 2 cycles; read = DRAIN_CYCLES + 3.

Reset
REQ-032 reset_n low: state IDLE, counter 0, pipe_stall 0, host_ack 0, host_rdata 0, latched addr/we 0; mid-transaction reset aborts with no ack and no RF write.
REQ-033 Outputs derived combinationally in IDLE follow inputs even during reset except rf_we, which is forced 0.

Structure
REQ-034 Shared package holds wb_sel encodings (WB_SEL_MEM/ALU/OFF/HOST) and FSM state encoding.
REQ-035 One sub-module: rf_wb_src_decode (pure combinational REQ-021 decode), reused by the datapath mux.

Verification
REQ-036 Decode sweep: all 16 flag combos in IDLE; e.g. MOVI=1,SUBI=1 -> 10; LW=1,MOVI=1 -> 00; ADDI=1,MOVI=1 -> 01.
REQ-037 Host write, DRAIN_CYCLES=4: req at cycle 0, addr 7 -> rf_we=1,wb_sel=11,rf_waddr=7 at cycle 5, host_ack at cycle 6.
REQ-038 Host read addr 3, RF returns 64'hDEAD_BEEF_0123_4567 -> host_rdata equals it with host_ack at cycle 7.
REQ-039 Pipeline write (wb_we=1, addr 9, ADDI) during DRAIN -> rf_we=1, rf_waddr=9, wb_sel=01 passes through.
REQ-040 reset_n low in DRAIN cycle 2 -> no rf_we, no host_ack, pipe_stall 0 immediately, state IDLE.
REQ-041 Back-to-back: req held after ack -> second transaction starts next cycle, exactly two ack pulses.
